// File: rtl/multi_ch_freq_serial_out.sv
// NUM_CH-channel serial pattern generator fed by a UART byte-packet parser.
// Optional parser inter-byte timeout is enabled by defining PARSER_TIMEOUT_EN.
module multi_ch_freq_serial_out #(
  parameter int         NUM_CH      = 16,
  parameter int         DATA_BIT    = 16,
  parameter logic [7:0] SLOW_PERIOD = 8'd20,
  parameter logic [7:0] FAST_PERIOD = 8'd5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        data_i,
  input  logic              rx_done_tick_i,
  output logic [NUM_CH-1:0] serial_out_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] done_tick_o,
  output logic              cmd_err_o
);

  localparam int NBYTES = DATA_BIT / 8;
  localparam int BCW    = $clog2(NBYTES + 1);
  localparam int IDXW   = $clog2(DATA_BIT);
  localparam logic [BCW-1:0]  LOAD_LAST   = BCW'(NBYTES - 1);
  localparam logic [BCW-1:0]  PERIOD_LAST = BCW'(1);
  localparam logic [IDXW-1:0] IDX_LAST    = IDXW'(DATA_BIT - 1);
  localparam logic [5:0]      BCAST       = 6'h3F;

  typedef enum logic [1:0] {
    CMD_LOAD   = 2'b00,
    CMD_PERIOD = 2'b01,
    CMD_START  = 2'b10,
    CMD_STOP   = 2'b11
  } cmd_e;

  typedef enum logic {
    P_IDLE,
    P_PAYLOAD
  } pstate_e;

  typedef enum logic {
    CH_IDLE,
    CH_SHIFT
  } chstate_e;

  pstate_e              pstate_q, pstate_d;
  cmd_e                 cmd_q, cmd_d;
  logic [5:0]           ch_q, ch_d;
  logic [BCW-1:0]       cnt_q, cnt_d;
  logic [DATA_BIT-1:0]  buf_q, buf_d;
  logic                 err_q, err_d;

`ifdef PARSER_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(TIMEOUT_CYC);
  logic [GW-1:0]        gap_q, gap_d;
`endif

  chstate_e             ch_st_q   [NUM_CH];
  chstate_e             ch_st_d   [NUM_CH];
  logic [DATA_BIT-1:0]  pattern_q [NUM_CH];
  logic [DATA_BIT-1:0]  pattern_d [NUM_CH];
  logic [DATA_BIT-1:0]  shift_q   [NUM_CH];
  logic [DATA_BIT-1:0]  shift_d   [NUM_CH];
  logic [IDXW-1:0]      idx_q     [NUM_CH];
  logic [IDXW-1:0]      idx_d     [NUM_CH];
  logic [7:0]           per_q     [NUM_CH];
  logic [7:0]           per_d     [NUM_CH];
  logic [7:0]           slow_q    [NUM_CH];
  logic [7:0]           slow_d    [NUM_CH];
  logic [7:0]           fast_q    [NUM_CH];
  logic [7:0]           fast_d    [NUM_CH];
  logic [NUM_CH-1:0]    rep_q, rep_d;
  logic [NUM_CH-1:0]    serial_q, serial_d;
  logic [NUM_CH-1:0]    done_q, done_d;

  cmd_e                 cur_cmd;
  logic [5:0]           cur_ch;
  logic [BCW-1:0]       last_idx;
  logic                 last_byte;
  logic                 ch_ok;
  logic [DATA_BIT-1:0]  load_pat;
  logic [7:0]           slow_new;
  logic [7:0]           fast_new;
  logic [NUM_CH-1:0]    hit;

  // In IDLE the command comes straight from byte0; afterwards from the latched header.
  always_comb begin
    cur_cmd = (pstate_q == P_IDLE) ? cmd_e'(data_i[7:6]) : cmd_q;
    cur_ch  = (pstate_q == P_IDLE) ? data_i[5:0] : ch_q;
    unique case (cur_cmd)
      CMD_LOAD:   last_idx = LOAD_LAST;
      CMD_PERIOD: last_idx = PERIOD_LAST;
      default:    last_idx = '0;
    endcase
    last_byte = rx_done_tick_i &&
                ((pstate_q == P_IDLE) ? (cur_cmd == CMD_STOP) : (cnt_q == last_idx));
    ch_ok     = (cur_ch == BCAST) || (32'(cur_ch) < NUM_CH);
    load_pat  = DATA_BIT'({data_i, buf_q} >> 8);
    slow_new  = (buf_q[DATA_BIT-1 -: 8] == 8'd0) ? 8'd1 : buf_q[DATA_BIT-1 -: 8];
    fast_new  = (data_i == 8'd0) ? 8'd1 : data_i;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = last_byte && ((cur_ch == BCAST) || (cur_ch == 6'(i)));
    end
  end

  always_comb begin
    pstate_d = pstate_q;
    cmd_d    = cmd_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    err_d    = 1'b0;
`ifdef PARSER_TIMEOUT_EN
    gap_d    = '0;
`endif
    if (rx_done_tick_i) begin
      if (pstate_q == P_IDLE) begin
        cmd_d = cur_cmd;
        ch_d  = cur_ch;
        cnt_d = '0;
        if (cur_cmd != CMD_STOP) pstate_d = P_PAYLOAD;
      end else begin
        buf_d = load_pat;
        cnt_d = cnt_q + BCW'(1);
        if (last_byte) pstate_d = P_IDLE;
      end
      if (last_byte && !ch_ok) err_d = 1'b1;
    end
`ifdef PARSER_TIMEOUT_EN
    else if (pstate_q == P_PAYLOAD) begin
      if (gap_q == GAP_LIMIT) begin
        pstate_d = P_IDLE;
        err_d    = 1'b1;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end
`endif
  end

  // A command landing on a channel overrides whatever the shifter would do that cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_st_d[i]   = ch_st_q[i];
      pattern_d[i] = pattern_q[i];
      shift_d[i]   = shift_q[i];
      idx_d[i]     = idx_q[i];
      per_d[i]     = per_q[i];
      slow_d[i]    = slow_q[i];
      fast_d[i]    = fast_q[i];
      rep_d[i]     = rep_q[i];
      serial_d[i]  = serial_q[i];
      done_d[i]    = 1'b0;

      if (hit[i] && cur_cmd == CMD_LOAD) pattern_d[i] = load_pat;
      if (hit[i] && cur_cmd == CMD_PERIOD) begin
        slow_d[i] = slow_new;
        fast_d[i] = fast_new;
      end

      if (hit[i] && cur_cmd == CMD_STOP) begin
        ch_st_d[i]  = CH_IDLE;
        serial_d[i] = 1'b0;
      end else if (hit[i] && cur_cmd == CMD_START) begin
        rep_d[i]     = data_i[0];
        ch_st_d[i]   = CH_SHIFT;
        shift_d[i]   = pattern_q[i];
        idx_d[i]     = '0;
        serial_d[i]  = pattern_q[i][0];
        per_d[i]     = (pattern_q[i][0] ? fast_q[i] : slow_q[i]) - 8'd1;
      end else if (ch_st_q[i] == CH_SHIFT) begin
        if (per_q[i] != 8'd0) begin
          per_d[i] = per_q[i] - 8'd1;
        end else if (idx_q[i] != IDX_LAST) begin
          shift_d[i]  = shift_q[i] >> 1;
          idx_d[i]    = idx_q[i] + IDXW'(1);
          serial_d[i] = shift_q[i][1];
          per_d[i]    = (shift_q[i][1] ? fast_q[i] : slow_q[i]) - 8'd1;
        end else if (rep_q[i]) begin
          shift_d[i]  = pattern_q[i];
          idx_d[i]    = '0;
          serial_d[i] = pattern_q[i][0];
          per_d[i]    = (pattern_q[i][0] ? fast_q[i] : slow_q[i]) - 8'd1;
        end else begin
          ch_st_d[i]  = CH_IDLE;
          serial_d[i] = 1'b0;
          done_d[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pstate_q <= P_IDLE;
      cmd_q    <= CMD_LOAD;
      ch_q     <= '0;
      cnt_q    <= '0;
      buf_q    <= '0;
      err_q    <= 1'b0;
`ifdef PARSER_TIMEOUT_EN
      gap_q    <= '0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        ch_st_q[i]   <= CH_IDLE;
        pattern_q[i] <= '0;
        shift_q[i]   <= '0;
        idx_q[i]     <= '0;
        per_q[i]     <= '0;
        slow_q[i]    <= SLOW_PERIOD;
        fast_q[i]    <= FAST_PERIOD;
      end
      rep_q    <= '0;
      serial_q <= '0;
      done_q   <= '0;
    end else begin
      pstate_q  <= pstate_d;
      cmd_q     <= cmd_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      err_q     <= err_d;
`ifdef PARSER_TIMEOUT_EN
      gap_q     <= gap_d;
`endif
      ch_st_q   <= ch_st_d;
      pattern_q <= pattern_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      per_q     <= per_d;
      slow_q    <= slow_d;
      fast_q    <= fast_d;
      rep_q     <= rep_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy_o[i] = (ch_st_q[i] == CH_SHIFT);
    end
  end

  assign serial_out_o = serial_q;
  assign done_tick_o  = done_q;
  assign cmd_err_o    = err_q;

endmodule

// File: tb/tb_multi_ch_freq_serial_out.sv
// Directed bench for multi_ch_freq_serial_out; expected waveforms come from hand-derived
// bit patterns and periods.
module tb_multi_ch_freq_serial_out;

  localparam int NUM_CH      = 16;
  localparam int DATA_BIT    = 16;
  localparam int TIMEOUT_CYC = 40;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [7:0]        data_i = 8'd0;
  logic              rx_done_tick_i = 1'b0;
  logic [NUM_CH-1:0] serial_out_o;
  logic [NUM_CH-1:0] busy_o;
  logic [NUM_CH-1:0] done_tick_o;
  logic              cmd_err_o;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk_i = ~clk_i;

  multi_ch_freq_serial_out #(
    .NUM_CH     (NUM_CH),
    .DATA_BIT   (DATA_BIT),
    .SLOW_PERIOD(8'd20),
    .FAST_PERIOD(8'd5),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_i        (data_i),
    .rx_done_tick_i(rx_done_tick_i),
    .serial_out_o  (serial_out_o),
    .busy_o        (busy_o),
    .done_tick_o   (done_tick_o),
    .cmd_err_o     (cmd_err_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one byte strobe; on return the DUT's response to that byte is visible.
  task automatic send_byte(input logic [7:0] b);
    data_i         = b;
    rx_done_tick_i = 1'b1;
    step();
    rx_done_tick_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    n_cmp++;
    if (serial_out_o !== '0) begin
      n_mis++;
      $display("[TB] FAIL reset_serial got=%h exp=0", serial_out_o);
    end
    n_cmp++;
    if (busy_o !== '0) begin
      n_mis++;
      $display("[TB] FAIL reset_busy got=%h exp=0", busy_o);
    end
    n_cmp++;
    if (done_tick_o !== '0) begin
      n_mis++;
      $display("[TB] FAIL reset_done got=%h exp=0", done_tick_o);
    end
    n_cmp++;
    if (cmd_err_o !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL reset_err got=%b exp=0", cmd_err_o);
    end
  endtask

  task automatic test_one_shot();
    logic [15:0] pat;
    int          per;
    int          cyc;
    pat = 16'h0005;
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h80); send_byte(8'h00);
    cyc = 0;
    for (int b = 0; b < 16; b++) begin
      per = pat[b] ? 5 : 20;
      for (int k = 0; k < per; k++) begin
        n_cmp++;
        if ({busy_o[0], serial_out_o[0], done_tick_o[0]} !== {1'b1, pat[b], 1'b0}) begin
          n_mis++;
          $display("[TB] FAIL one_shot cyc=%0d got=%b exp=%b", cyc,
                   {busy_o[0], serial_out_o[0], done_tick_o[0]}, {1'b1, pat[b], 1'b0});
        end
        step();
        cyc++;
      end
    end
    n_cmp++;
    if ({busy_o[0], serial_out_o[0], done_tick_o[0]} !== 3'b001) begin
      n_mis++;
      $display("[TB] FAIL one_shot_end cyc=%0d got=%b exp=001", cyc,
               {busy_o[0], serial_out_o[0], done_tick_o[0]});
    end
    step();
    n_cmp++;
    if (done_tick_o[0] !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL one_shot_done_width got=%b exp=0", done_tick_o[0]);
    end
  endtask

  task automatic test_period_repeat();
    logic [15:0] pat;
    int          per;
    send_byte(8'h43); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h83); send_byte(8'h01);
    for (int c = 0; c < 40; c++) begin
      n_cmp++;
      if ({busy_o[3], serial_out_o[3], done_tick_o[3]} !== 3'b110) begin
        n_mis++;
        $display("[TB] FAIL repeat_high cyc=%0d got=%b exp=110", c,
                 {busy_o[3], serial_out_o[3], done_tick_o[3]});
      end
      step();
    end
    send_byte(8'hC3);
    n_cmp++;
    if ({busy_o[3], serial_out_o[3], done_tick_o[3]} !== 3'b000) begin
      n_mis++;
      $display("[TB] FAIL repeat_stop got=%b exp=000",
               {busy_o[3], serial_out_o[3], done_tick_o[3]});
    end
    step();
    n_cmp++;
    if (done_tick_o[3] !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL repeat_stop_done got=%b exp=0", done_tick_o[3]);
    end
    // Slow period was written as 0, so each 0-bit must last a single cycle.
    pat = 16'h0002;
    send_byte(8'h03); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h83); send_byte(8'h00);
    for (int b = 0; b < 16; b++) begin
      per = pat[b] ? 2 : 1;
      for (int k = 0; k < per; k++) begin
        n_cmp++;
        if ({busy_o[3], serial_out_o[3], done_tick_o[3]} !== {1'b1, pat[b], 1'b0}) begin
          n_mis++;
          $display("[TB] FAIL min_period bit=%0d got=%b exp=%b", b,
                   {busy_o[3], serial_out_o[3], done_tick_o[3]}, {1'b1, pat[b], 1'b0});
        end
        step();
      end
    end
    n_cmp++;
    if ({busy_o[3], serial_out_o[3], done_tick_o[3]} !== 3'b001) begin
      n_mis++;
      $display("[TB] FAIL min_period_end got=%b exp=001",
               {busy_o[3], serial_out_o[3], done_tick_o[3]});
    end
    step();
  endtask

  task automatic test_broadcast();
    logic [15:0] pat;
    int          per;
    pat = 16'h00FF;
    send_byte(8'h7F); send_byte(8'd20); send_byte(8'd5);
    send_byte(8'h3F); send_byte(8'hFF); send_byte(8'h00);
    send_byte(8'hBF); send_byte(8'h00);
    for (int b = 0; b < 16; b++) begin
      per = pat[b] ? 5 : 20;
      for (int k = 0; k < per; k++) begin
        n_cmp++;
        if (busy_o !== 16'hFFFF || serial_out_o !== {16{pat[b]}} || done_tick_o !== 16'h0) begin
          n_mis++;
          $display("[TB] FAIL bcast bit=%0d got busy=%h ser=%h done=%h exp busy=ffff ser=%h done=0",
                   b, busy_o, serial_out_o, done_tick_o, {16{pat[b]}});
        end
        step();
      end
    end
    n_cmp++;
    if (busy_o !== 16'h0 || serial_out_o !== 16'h0 || done_tick_o !== 16'hFFFF) begin
      n_mis++;
      $display("[TB] FAIL bcast_end got busy=%h ser=%h done=%h exp busy=0 ser=0 done=ffff",
               busy_o, serial_out_o, done_tick_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_ser;
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h81); send_byte(8'h00);
    for (int c = 0; c < 10; c++) begin
      exp_ser = (c < 5);
      n_cmp++;
      if ({busy_o[1], serial_out_o[1], done_tick_o[1]} !== {1'b1, exp_ser, 1'b0}) begin
        n_mis++;
        $display("[TB] FAIL first_run cyc=%0d got=%b exp=%b", c,
                 {busy_o[1], serial_out_o[1], done_tick_o[1]}, {1'b1, exp_ser, 1'b0});
      end
      step();
    end
    // Restart mid-pattern, then reload the pattern while the old one is still shifting.
    send_byte(8'h81); send_byte(8'h00);
    for (int c = 0; c < 305; c++) begin
      if (c == 5) begin
        send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
        c = 8;
      end
      exp_ser = (c < 5);
      n_cmp++;
      if ({busy_o[1], serial_out_o[1], done_tick_o[1]} !== {1'b1, exp_ser, 1'b0}) begin
        n_mis++;
        $display("[TB] FAIL restart_run cyc=%0d got=%b exp=%b", c,
                 {busy_o[1], serial_out_o[1], done_tick_o[1]}, {1'b1, exp_ser, 1'b0});
      end
      step();
    end
    n_cmp++;
    if ({busy_o[1], serial_out_o[1], done_tick_o[1]} !== 3'b001) begin
      n_mis++;
      $display("[TB] FAIL restart_end got=%b exp=001",
               {busy_o[1], serial_out_o[1], done_tick_o[1]});
    end
    step();
    send_byte(8'h81); send_byte(8'h00);
    n_cmp++;
    if ({busy_o[1], serial_out_o[1]} !== 2'b11) begin
      n_mis++;
      $display("[TB] FAIL new_pattern got=%b exp=11", {busy_o[1], serial_out_o[1]});
    end
    send_byte(8'hC1);
    n_cmp++;
    if (busy_o !== 16'h0) begin
      n_mis++;
      $display("[TB] FAIL new_pattern_stop got=%h exp=0", busy_o);
    end
  endtask

  task automatic test_bad_channel();
    send_byte(8'h28);
    n_cmp++;
    if (cmd_err_o !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL bad_ch_early got=%b exp=0", cmd_err_o);
    end
    send_byte(8'h00);
    send_byte(8'h00);
    n_cmp++;
    if (cmd_err_o !== 1'b1 || busy_o !== 16'h0 || serial_out_o !== 16'h0) begin
      n_mis++;
      $display("[TB] FAIL bad_ch_load got err=%b busy=%h ser=%h exp err=1 busy=0 ser=0",
               cmd_err_o, busy_o, serial_out_o);
    end
    step();
    n_cmp++;
    if (cmd_err_o !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL bad_ch_err_width got=%b exp=0", cmd_err_o);
    end
    send_byte(8'hA8); send_byte(8'h01);
    n_cmp++;
    if (cmd_err_o !== 1'b1 || busy_o !== 16'h0) begin
      n_mis++;
      $display("[TB] FAIL bad_ch_start got err=%b busy=%h exp err=1 busy=0", cmd_err_o, busy_o);
    end
    send_byte(8'hE8);
    n_cmp++;
    if (cmd_err_o !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL bad_ch_stop got=%b exp=1", cmd_err_o);
    end
    step();
    // Channel 8 keeps its broadcast pattern 0x00FF, so bit0 must be 1.
    send_byte(8'h88); send_byte(8'h00);
    n_cmp++;
    if (cmd_err_o !== 1'b0 || busy_o !== 16'h0100 || serial_out_o !== 16'h0100) begin
      n_mis++;
      $display("[TB] FAIL good_after_bad got err=%b busy=%h ser=%h exp err=0 busy=0100 ser=0100",
               cmd_err_o, busy_o, serial_out_o);
    end
    send_byte(8'hC8);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h80); send_byte(8'h00);
    step(); step(); step();
    send_byte(8'h00);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    n_cmp++;
    if (busy_o !== 16'h0 || serial_out_o !== 16'h0 || done_tick_o !== 16'h0 || cmd_err_o !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL reset_mid got busy=%h ser=%h done=%h err=%b exp all 0",
               busy_o, serial_out_o, done_tick_o, cmd_err_o);
    end
    send_byte(8'h80); send_byte(8'h00);
    n_cmp++;
    if ({busy_o[0], serial_out_o[0]} !== 2'b10) begin
      n_mis++;
      $display("[TB] FAIL reset_mid_restart got=%b exp=10", {busy_o[0], serial_out_o[0]});
    end
    send_byte(8'hC0);
  endtask

  task automatic test_parser_gap();
`ifdef PARSER_TIMEOUT_EN
    int pulses;
    send_byte(8'h05); send_byte(8'h10);
    pulses = 0;
    for (int c = 0; c < TIMEOUT_CYC + 10; c++) begin
      if (cmd_err_o === 1'b1) pulses++;
      step();
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_mis++;
      $display("[TB] FAIL timeout_pulses got=%0d exp=1", pulses);
    end
    send_byte(8'h85); send_byte(8'h00);
    n_cmp++;
    if ({busy_o[5], serial_out_o[5]} !== 2'b11) begin
      n_mis++;
      $display("[TB] FAIL timeout_new_byte0 got=%b exp=11", {busy_o[5], serial_out_o[5]});
    end
`else
    send_byte(8'h05); send_byte(8'h10);
    for (int c = 0; c < 60; c++) begin
      n_cmp++;
      if (cmd_err_o !== 1'b0) begin
        n_mis++;
        $display("[TB] FAIL wait_no_err cyc=%0d got=%b exp=0", c, cmd_err_o);
      end
      step();
    end
    send_byte(8'h22);
    send_byte(8'h85); send_byte(8'h00);
    n_cmp++;
    if ({busy_o[5], serial_out_o[5]} !== 2'b10) begin
      n_mis++;
      $display("[TB] FAIL wait_late_byte got=%b exp=10", {busy_o[5], serial_out_o[5]});
    end
`endif
    send_byte(8'hC5);
    n_cmp++;
    if (busy_o[5] !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL gap_stop got=%b exp=0", busy_o[5]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_period_repeat();
    test_broadcast();
    test_back_to_back();
    test_bad_channel();
    test_reset_mid();
    test_parser_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
